// File: rtl/display_scan_decoder.sv
// Decodes a scanned 4-digit 7-segment stream back to BCD; publishes after STABLE_FRAMES identical frames, all outputs registered.
// Optional DISPLAY_SCAN_BLANK_EN: pattern 00 in slot 0 (hours1 leading-zero blank) decodes to 0.
module display_scan_decoder #(
   parameter int STABLE_FRAMES = 2,
   parameter int SCAN_TIMEOUT  = 1024
) (
   input  logic       Clk,
   input  logic       Clr,
   input  logic [6:0] display_out,
   input  logic [3:0] segment_digit,
   output logic [3:0] hours1,
   output logic [3:0] hours0,
   output logic [3:0] mins1,
   output logic [3:0] mins0,
   output logic       frame_valid,
   output logic       upd,
   output logic       seq_err,
   output logic       seg_err
);

   localparam int TW = $clog2(SCAN_TIMEOUT + 1);
   localparam int SW = $clog2(STABLE_FRAMES + 1);

   typedef enum logic {S_HUNT, S_SCAN} state_t;

   state_t               r_state;
   logic [1:0]           r_slot;
   logic [TW-1:0]        r_tmo;
   logic [SW-1:0]        r_stable;
   logic                 r_poison;
   logic                 r_slot_bad;
   logic [3:0][3:0]      r_shadow;
   logic [3:0][3:0]      r_rec;
   logic [3:0][3:0]      r_pub;

   logic                 w_zero, w_onehot, w_multi;
   logic [1:0]           w_idx, w_next_slot;
   logic                 w_hold, w_adv, w_ooo, w_start, w_complete;
   logic [4:0]           w_dec;
   logic                 w_blank_ok, w_bad;
   logic [3:0]           w_dig;
   logic                 w_same;
   logic [SW-1:0]        w_cnt;

   function automatic logic [4:0] f_decode(input logic [6:0] i_pat);
      case (i_pat)
         7'h7E:   f_decode = {1'b1, 4'd0};
         7'h30:   f_decode = {1'b1, 4'd1};
         7'h6D:   f_decode = {1'b1, 4'd2};
         7'h79:   f_decode = {1'b1, 4'd3};
         7'h33:   f_decode = {1'b1, 4'd4};
         7'h5B:   f_decode = {1'b1, 4'd5};
         7'h5F:   f_decode = {1'b1, 4'd6};
         7'h70:   f_decode = {1'b1, 4'd7};
         7'h7F:   f_decode = {1'b1, 4'd8};
         7'h7B:   f_decode = {1'b1, 4'd9};
         default: f_decode = {1'b0, 4'hF};
      endcase
   endfunction

   always_comb begin
      w_zero   = (segment_digit == 4'd0);
      w_onehot = !w_zero && ((segment_digit & (segment_digit - 4'd1)) == 4'd0);
      w_multi  = !w_zero && !w_onehot;
      w_idx    = 2'd0;
      if (segment_digit[1]) w_idx = 2'd1;
      if (segment_digit[2]) w_idx = 2'd2;
      if (segment_digit[3]) w_idx = 2'd3;
      w_next_slot = r_slot + 2'd1;

      w_hold     = (r_state == S_SCAN) && w_onehot && (w_idx == r_slot);
      w_adv      = (r_state == S_SCAN) && w_onehot && (w_idx == w_next_slot);
      w_ooo      = (r_state == S_SCAN) && w_onehot && !w_hold && !w_adv;
      w_start    = (r_state == S_HUNT) && w_onehot && (w_idx == 2'd0);
      w_complete = w_adv && (r_slot == 2'd3);

      w_dec = f_decode(display_out);
`ifdef DISPLAY_SCAN_BLANK_EN
      w_blank_ok = (display_out == 7'h00) && (w_idx == 2'd0);
`else
      w_blank_ok = 1'b0;
`endif
      w_bad = !(w_dec[4] || w_blank_ok);
      w_dig = w_blank_ok ? 4'd0 : w_dec[3:0];

      // Frame-completion stable count (only consumed when w_complete and clean)
      w_same = (r_shadow == r_rec);
      if (!w_same)
         w_cnt = SW'(1);
      else if (r_stable == SW'(STABLE_FRAMES))
         w_cnt = r_stable;
      else
         w_cnt = r_stable + SW'(1);
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         r_state     <= S_HUNT;
         r_slot      <= 2'd0;
         r_tmo       <= '0;
         r_stable    <= '0;
         r_poison    <= 1'b0;
         r_slot_bad  <= 1'b0;
         r_shadow    <= '0;
         r_rec       <= '0;
         r_pub       <= '0;
         frame_valid <= 1'b0;
         upd         <= 1'b0;
         seq_err     <= 1'b0;
         seg_err     <= 1'b0;
      end else begin
         upd     <= 1'b0;
         seq_err <= 1'b0;
         seg_err <= 1'b0;
         if (w_multi || w_ooo) begin
            seq_err     <= 1'b1;
            frame_valid <= 1'b0;
            r_state     <= S_HUNT;
            r_stable    <= '0;
            r_tmo       <= '0;
            r_poison    <= 1'b0;
         end else if (r_state == S_HUNT) begin
            if (w_start) begin
               r_state        <= S_SCAN;
               r_slot         <= 2'd0;
               r_tmo          <= '0;
               r_shadow[0]    <= w_dig;
               r_poison       <= w_bad;
               r_slot_bad     <= w_bad;
               seg_err        <= w_bad;
            end
         end else begin
            if (w_hold) begin
               r_shadow[w_idx] <= w_dig;
               seg_err         <= w_bad && !r_slot_bad;
               r_slot_bad      <= r_slot_bad || w_bad;
               r_poison        <= r_poison || w_bad;
            end
            if (w_adv) begin
               // Advance beats a simultaneous timeout expiry
               r_slot          <= w_next_slot;
               r_tmo           <= '0;
               r_shadow[w_idx] <= w_dig;
               seg_err         <= w_bad;
               r_slot_bad      <= w_bad;
               if (w_complete) begin
                  r_poison <= w_bad;
                  if (r_poison) begin
                     r_stable <= '0;
                  end else begin
                     r_stable <= w_cnt;
                     if (!w_same) r_rec <= r_shadow;
                     if (w_cnt == SW'(STABLE_FRAMES)) begin
                        r_pub       <= r_shadow;
                        frame_valid <= 1'b1;
                        upd         <= (r_shadow != r_pub);
                     end
                  end
               end else begin
                  r_poison <= r_poison || w_bad;
               end
            end else if (r_tmo == TW'(SCAN_TIMEOUT - 1)) begin
               frame_valid <= 1'b0;
               r_state     <= S_HUNT;
               r_stable    <= '0;
               r_tmo       <= '0;
            end else begin
               r_tmo <= r_tmo + TW'(1);
            end
         end
      end
   end

   assign hours1 = r_pub[0];
   assign hours0 = r_pub[1];
   assign mins1  = r_pub[2];
   assign mins0  = r_pub[3];

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: scan order, stability filter, errors, timeout, blanking.
module tb_display_scan_decoder;

   logic       Clk = 1'b0;
   logic       Clr = 1'b1;
   logic [6:0] display_out = 7'h00;
   logic [3:0] segment_digit = 4'd0;
   logic [3:0] hours1, hours0, mins1, mins0;
   logic       frame_valid, upd, seq_err, seg_err;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [6:0] P1 = 7'h30;
   localparam logic [6:0] P2 = 7'h6D;
   localparam logic [6:0] P3 = 7'h79;
   localparam logic [6:0] P4 = 7'h33;
   localparam logic [6:0] P5 = 7'h5B;

   display_scan_decoder #(.STABLE_FRAMES(2), .SCAN_TIMEOUT(1024)) dut (
      .Clk(Clk), .Clr(Clr), .display_out(display_out), .segment_digit(segment_digit),
      .hours1(hours1), .hours0(hours0), .mins1(mins1), .mins0(mins0),
      .frame_valid(frame_valid), .upd(upd), .seq_err(seq_err), .seg_err(seg_err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input logic [3:0] en, input logic [6:0] pat);
      segment_digit = en;
      display_out   = pat;
      @(posedge Clk);
      #1;
   endtask

   task automatic rest(input logic [6:0] b, input logic [6:0] c, input logic [6:0] d);
      step(4'b0010, b);
      step(4'b0100, c);
      step(4'b1000, d);
   endtask

   initial begin
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_digits", {hours1, hours0}, 8'h00);
      chk("rst_digits_m", {mins1, mins0}, 8'h00);
      chk("rst_flags", {4'd0, frame_valid, upd, seq_err, seg_err}, 8'h00);
      Clr = 1'b0;

      // 12:34 with one-cycle slots: publish on the third slot-0 edge
      step(4'b0001, P1); rest(P2, P3, P4);
      step(4'b0001, P1);
      chk("e4_not_yet", {6'd0, frame_valid, upd}, 8'h00);
      rest(P2, P3, P4);
      step(4'b0001, P1);
      chk("e8_digits", {hours1, hours0, mins1, mins0} >> 8, 8'h12);
      chk("e8_digits_m", {mins1, mins0}, 8'h34);
      chk("e8_valid_upd", {6'd0, frame_valid, upd}, 8'h03);
      rest(P2, P3, P4);
      step(4'b0001, P1);
      chk("e12_no_upd", {6'd0, frame_valid, upd}, 8'h02);

      // Single 12:35 frame then back to 12:34: no change
      rest(P2, P3, P5);
      step(4'b0001, P1);
      chk("glitch1", {3'd0, upd, mins0}, 8'h04);
      rest(P2, P3, P4);
      step(4'b0001, P1);
      chk("glitch2", {3'd0, upd, mins0}, 8'h04);
      rest(P2, P3, P4);
      step(4'b0001, P1);
      chk("glitch3", {2'd0, frame_valid, upd, mins0}, 8'h24);

      // Hold 12:35 for two frames
      rest(P2, P3, P5);
      step(4'b0001, P1);
      chk("hold35_1", {3'd0, upd, mins0}, 8'h04);
      rest(P2, P3, P5);
      step(4'b0001, P1);
      chk("hold35_2", {3'd0, upd, mins0}, 8'h15);

      // Out-of-order enable
      step(4'b0100, P3);
      chk("seq_err", {2'd0, seq_err, frame_valid, mins0}, 8'h25);

      // Poisoned frame after hunt (slot 2 = 0x01 held two cycles), then two clean 12:34 frames
      step(4'b0001, P1);
      chk("seq_err_clr", {7'd0, seq_err}, 8'h00);
      step(4'b0010, P2);
      step(4'b0100, 7'h01);
      chk("seg_err_pulse", {7'd0, seg_err}, 8'h01);
      step(4'b0100, 7'h01);
      chk("seg_err_once", {7'd0, seg_err}, 8'h00);
      step(4'b1000, P4);
      step(4'b0001, P1);
      chk("poison_frame", {2'd0, frame_valid, seg_err, mins0}, 8'h05);
      rest(P2, P3, P4);
      step(4'b0001, P1);
      chk("clean1", {2'd0, frame_valid, upd, mins0}, 8'h05);
      rest(P2, P3, P4);
      step(4'b0001, P1);
      chk("clean2", {2'd0, frame_valid, upd, mins0}, 8'h34);

      // Freeze on slot 1
      step(4'b0010, P2);
      repeat (1000) step(4'b0010, P2);
      chk("tmo_before", {7'd0, frame_valid}, 8'h01);
      repeat (30) step(4'b0010, P2);
      chk("tmo_after", {3'd0, frame_valid, mins0}, 8'h04);
      step(4'b0001, P1); rest(P2, P3, P4);
      step(4'b0001, P1);
      chk("resume1", {6'd0, frame_valid, upd}, 8'h00);
      rest(P2, P3, P4);
      step(4'b0001, P1);
      chk("resume2", {2'd0, frame_valid, upd, mins0}, 8'h24);

      // Blank hours1
      rest(P2, P3, P4);
      step(4'b0001, 7'h00);
`ifdef DISPLAY_SCAN_BLANK_EN
      chk("blank_seg", {7'd0, seg_err}, 8'h00);
`else
      chk("blank_seg", {7'd0, seg_err}, 8'h01);
`endif
      rest(P2, P3, P4);
      step(4'b0001, 7'h00);
      chk("blank_f1", {3'd0, frame_valid, hours1}, 8'h11);
      rest(P2, P3, P4);
      step(4'b0001, 7'h00);
`ifdef DISPLAY_SCAN_BLANK_EN
      chk("blank_f2", {3'd0, upd, hours1}, 8'h10);
`else
      chk("blank_f2", {3'd0, upd, hours1}, 8'h01);
`endif

      // Asynchronous clear mid-frame
      step(4'b0010, P2);
      Clr = 1'b1;
      #1;
      chk("clr_mid", {frame_valid, 3'd0, hours0}, 8'h00);
      chk("clr_mid_m", {mins1, mins0}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
